butterfly_row_stage: RTL and testbench

Parametrised, streaming first butterfly stage of the row DCT. It accepts one pixel per cycle over a valid/ready handshake and collects a row of N samples. It then emits all N/2 pair sums and N/2 pair differences, `p[i] ± p[N-1-i]`, as one registered parallel word. An optional per-pixel level shift (unsigned to signed, subtract 2^(WIDTH-1)) and block-row tracking are built in, so the stage can sit directly between the pixel line reader and the DCT rotation stages.

---
 rtl/jpeg_dct_pkg.sv | 26 ++
 rtl/butterfly_core.sv | 36 +++
 rtl/butterfly_row_stage.sv | 153 +++++++++++++++
 tb/tb_butterfly_row_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_dct_pkg.sv
// ---------------------------------------------------------------------------
// jpeg_dct_pkg
// Shared definitions for the row DCT pipeline: default geometry constants,
// the lane-offset helper used to address flattened parallel words, and the
// level-shift helper that moves an unsigned pixel into the signed domain.
// ---------------------------------------------------------------------------
package jpeg_dct_pkg;

    // Default geometry: 8-bit pixels, 8-point rows, 8-row blocks.
    localparam int DCT_WIDTH = 8;
    localparam int DCT_N     = 8;
    localparam int DCT_ROWS  = 8;

    // Bit offset of lane `lane` inside a flattened word of `lane_w`-bit lanes.
    function automatic int lane_lsb(input int lane, input int lane_w);
        return lane * lane_w;
    endfunction

    // Subtracting 2^(WIDTH-1) from an unsigned sample and reinterpreting it
    // as two's complement is the same as inverting its MSB. Only the MSB
    // changes, so the helper works on that bit alone and stays width-agnostic.
    function automatic logic level_shift_msb(input logic msb, input logic shift_en);
        return msb ^ shift_en;
    endfunction

endpackage : jpeg_dct_pkg

// File: rtl/butterfly_core.sv
// ---------------------------------------------------------------------------
// butterfly_core
// Purely combinational first butterfly of an N-point row DCT.
//   in_flat  : N signed WIDTH-bit samples, sample i at [i*WIDTH +: WIDTH]
//   out_flat : N signed (WIDTH+1)-bit lanes
//              lanes 0..N/2-1   = in[k] + in[N-1-k]
//              lanes N/2..N-1   = in[k] - in[N-1-k]   (k = lane - N/2)
// Operands are sign-extended by one bit, so the results are exact.
// ---------------------------------------------------------------------------
module butterfly_core
    import jpeg_dct_pkg::*;
#(
    parameter int N     = DCT_N,
    parameter int WIDTH = DCT_WIDTH
) (
    input  logic [N*WIDTH-1:0]     in_flat,
    output logic [N*(WIDTH+1)-1:0] out_flat
);

    localparam int W1 = WIDTH + 1;

    for (genvar k = 0; k < N / 2; k++) begin : g_pair
        logic signed [W1-1:0] a;
        logic signed [W1-1:0] b;

        // Sign-extend both members of the mirrored pair.
        assign a = {in_flat[lane_lsb(k, WIDTH) + WIDTH - 1],
                    in_flat[lane_lsb(k, WIDTH) +: WIDTH]};
        assign b = {in_flat[lane_lsb(N - 1 - k, WIDTH) + WIDTH - 1],
                    in_flat[lane_lsb(N - 1 - k, WIDTH) +: WIDTH]};

        assign out_flat[lane_lsb(k, W1)         +: W1] = a + b;
        assign out_flat[lane_lsb(k + N / 2, W1) +: W1] = a - b;
    end

endmodule : butterfly_core

// File: rtl/butterfly_row_stage.sv
// ---------------------------------------------------------------------------
// butterfly_row_stage
// Streaming first butterfly stage of the row DCT. Collects N pixels of a row
// (one per cycle, valid/ready), then presents all N/2 pair sums and N/2 pair
// differences as one registered parallel word.
//
// Ports
//   Clk, Rst         : rising-edge clock, synchronous active-high reset
//   In_Pixel         : WIDTH-bit sample (signed, or unsigned when shifted)
//   In_Level_Shift   : per-pixel request to subtract 2^(WIDTH-1)
//   In_Valid/Ready   : input handshake; Ready is a pure register output
//   Out_Data         : N lanes of WIDTH+1 bits, sums then differences
//   Out_Valid/Ready  : output handshake for one complete row
//   Out_Block_Last   : set with the row that closes a block of ROWS rows
//
// Buffering: one fill buffer plus the output register. If the output is
// stalled when a row completes, the row waits in the fill buffer (`full`)
// and input is blocked until the output register frees up.
// ---------------------------------------------------------------------------
module butterfly_row_stage
    import jpeg_dct_pkg::*;
#(
    parameter int WIDTH = DCT_WIDTH,
    parameter int N     = DCT_N,
    parameter int ROWS  = DCT_ROWS
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [WIDTH-1:0]         In_Pixel,
    input  logic                     In_Level_Shift,
    input  logic                     In_Valid,
    output logic                     In_Ready,
    output logic [N*(WIDTH+1)-1:0]   Out_Data,
    output logic                     Out_Valid,
    input  logic                     Out_Ready,
    output logic                     Out_Block_Last
);

    localparam int CW = $clog2(N);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(N - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [CW-1:0]            col;
    logic [RW-1:0]            row;
    logic                     full;
    logic                     out_valid_q;
    logic                     out_last_q;
    logic [N*(WIDTH+1)-1:0]   out_data_q;
    logic [WIDTH-1:0]         fill_buf [N];

    // ---------------------------------------------------------------------
    // Handshake decode
    // ---------------------------------------------------------------------
    logic             accept;
    logic             last_accept;
    logic             slot_free;
    logic             transfer;
    logic [WIDTH-1:0] pix_in;

    assign In_Ready    = !full;
    assign accept      = In_Valid && In_Ready;
    assign last_accept = accept && (col == COL_LAST);
    assign slot_free   = !out_valid_q || Out_Ready;
    // A row moves to the output either as its last pixel arrives, or later
    // from the fill buffer once a stalled output drains. `full` blocks input,
    // so the two sources never coincide.
    assign transfer    = (last_accept || full) && slot_free;

    assign pix_in = {level_shift_msb(In_Pixel[WIDTH-1], In_Level_Shift),
                     In_Pixel[WIDTH-2:0]};

    // ---------------------------------------------------------------------
    // Fill buffer
    // ---------------------------------------------------------------------
    // NOTE: the fill buffer is data-only storage with no reset; every slot
    // is rewritten before a row is ever transferred, so clearing it would
    // only add reset fan-out.
    always_ff @(posedge Clk) begin
        if (accept) begin
            fill_buf[col] <= pix_in;
        end
    end

    // ---------------------------------------------------------------------
    // Butterfly operands: on a same-cycle transfer the last sample has not
    // reached the buffer yet, so it is bypassed straight from the input.
    // ---------------------------------------------------------------------
    logic [N*WIDTH-1:0]     core_in;
    logic [N*(WIDTH+1)-1:0] core_out;

    // NOTE: every combinational output is given a default first so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        core_in = '0;
        for (int i = 0; i < N - 1; i++) begin
            core_in[lane_lsb(i, WIDTH) +: WIDTH] = fill_buf[i];
        end
        core_in[lane_lsb(N - 1, WIDTH) +: WIDTH] = full ? fill_buf[N-1] : pix_in;
    end

    butterfly_core #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_core (
        .in_flat  (core_in),
        .out_flat (core_out)
    );

    // ---------------------------------------------------------------------
    // Control and output register
    // ---------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignment so every flop sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            col         <= '0;
            row         <= '0;
            full        <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            // N is a power of two, so the natural wrap of col is the row wrap.
            if (accept) begin
                col <= col + 1'b1;
            end

            if (last_accept && !slot_free) begin
                full <= 1'b1;
            end else if (transfer) begin
                full <= 1'b0;
            end

            if (transfer) begin
                out_data_q  <= core_out;
                out_valid_q <= 1'b1;
                out_last_q  <= (row == ROW_LAST);
                row         <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else if (Out_Ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign Out_Data       = out_data_q;
    assign Out_Valid      = out_valid_q;
    assign Out_Block_Last = out_last_q;

endmodule : butterfly_row_stage

// File: tb/tb_butterfly_row_stage.sv
// ---------------------------------------------------------------------------
// tb_butterfly_row_stage
// Scoreboard bench for butterfly_row_stage. Two instances: the default
// 8x8 geometry and a 4-point row with 2-row blocks. Stimulus pushes the
// hand-computed row result; per-instance monitors compare at the negedge
// whenever Out_Valid is high (held rows are compared every cycle too).
// ---------------------------------------------------------------------------
module tb_butterfly_row_stage;

    typedef struct {
        logic [71:0] data;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Instance A: WIDTH=8, N=8, ROWS=8
    logic        rst = 1'b1;
    logic [7:0]  pix = '0;
    logic        shift = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [71:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;

    // Instance B: WIDTH=8, N=4, ROWS=2
    logic        rst4 = 1'b1;
    logic [7:0]  pix4 = '0;
    logic        shift4 = 1'b0;
    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [35:0] out_data4;
    logic        out_valid4;
    logic        out_ready4 = 1'b1;
    logic        out_last4;

    butterfly_row_stage #(.WIDTH(8), .N(8), .ROWS(8)) dut8 (
        .Clk(clk), .Rst(rst), .In_Pixel(pix), .In_Level_Shift(shift),
        .In_Valid(in_valid), .In_Ready(in_ready), .Out_Data(out_data),
        .Out_Valid(out_valid), .Out_Ready(out_ready), .Out_Block_Last(out_last)
    );

    butterfly_row_stage #(.WIDTH(8), .N(4), .ROWS(2)) dut4 (
        .Clk(clk), .Rst(rst4), .In_Pixel(pix4), .In_Level_Shift(shift4),
        .In_Valid(in_valid4), .In_Ready(in_ready4), .Out_Data(out_data4),
        .Out_Valid(out_valid4), .Out_Ready(out_ready4), .Out_Block_Last(out_last4)
    );

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t q8[$];
    exp_t q4[$];

    bit gap_on   = 1'b0;
    bit gap_prev = 1'b0;
    int gap_cyc  = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [71:0] pack(input int l[8], input int n);
        logic [71:0] d = '0;
        for (int k = 0; k < n; k++) d[k*9 +: 9] = 9'(l[k]);
        return d;
    endfunction

    task automatic push(input bit sel4, input int l[8], input bit last);
        exp_t e;
        e.data = pack(l, sel4 ? 4 : 8);
        e.last = last;
        if (sel4) q4.push_back(e);
        else      q8.push_back(e);
    endtask

    // Drive one pixel and return #1 after the edge that accepted it.
    task automatic send(input bit sel4, input logic [7:0] p, input bit s);
        int waited = 0;
        if (sel4) begin pix4 = p; shift4 = s; in_valid4 = 1'b1; end
        else      begin pix  = p; shift  = s; in_valid  = 1'b1; end
        while (!(sel4 ? in_ready4 : in_ready)) begin
            @(posedge clk); #1;
            waited++;
            if (waited > 200) begin
                check("send timeout in_ready", 72'(sel4 ? in_ready4 : in_ready), 72'd1);
                return;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
    endtask

    task automatic reset8();
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitors: compare whenever a row is presented; pop on handshake.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q8.size() == 0) begin
                check("dut8 unexpected row", 72'(q8.size()), 72'd1);
            end else begin
                check("dut8 row data", out_data, q8[0].data);
                check("dut8 block_last", 72'(out_last), 72'(q8[0].last));
                if (out_ready) begin
                    void'(q8.pop_front());
                    if (gap_on) begin
                        if (gap_prev) check("dut8 row spacing", 72'(cyc - gap_cyc), 72'd8);
                        gap_cyc  = cyc;
                        gap_prev = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst4 && out_valid4) begin
            if (q4.size() == 0) begin
                check("dut4 unexpected row", 72'(q4.size()), 72'd1);
            end else begin
                check("dut4 row data", 72'(out_data4), q4[0].data);
                check("dut4 block_last", 72'(out_last4), 72'(q4[0].last));
                if (out_ready4) void'(q4.pop_front());
            end
        end
    end

    initial begin
        int e[8];

        // ---------------- reset ----------------
        rst4 = 1'b1;
        reset8();
        rst4 = 1'b0;
        check("reset out_valid", 72'(out_valid), 72'd0);
        check("reset out_data", out_data, 72'd0);
        check("reset in_ready", 72'(in_ready), 72'd1);
        check("reset block_last", 72'(out_last), 72'd0);

        // ---------------- ramp, no shift (row 0) ----------------
        e = '{7, 7, 7, 7, -7, -5, -3, -1};
        push(0, e, 0);
        for (int i = 0; i < 7; i++) send(0, 8'(i), 0);
        check("ramp valid before last", 72'(out_valid), 72'd0);
        send(0, 8'd7, 0);
        check("ramp latency", 72'(out_valid), 72'd1);

        // ---------------- level shift extremes (rows 1, 2) ----------------
        e = '{254, 254, 254, 254, 0, 0, 0, 0};
        push(0, e, 0);
        for (int i = 0; i < 8; i++) send(0, 8'd255, 1);
        e = '{-256, -256, -256, -256, 0, 0, 0, 0};
        push(0, e, 0);
        for (int i = 0; i < 8; i++) send(0, 8'd0, 1);

        // ---------------- signed extremes, no shift (row 3) ----------------
        e = '{-1, -1, -1, -1, -255, -255, -255, -255};
        push(0, e, 0);
        for (int i = 0; i < 4; i++) send(0, 8'h80, 0);
        for (int i = 0; i < 4; i++) send(0, 8'h7f, 0);
        idle();
        repeat (3) @(posedge clk);
        #1;

        // ---------------- block tracking: 16 back-to-back rows ----------------
        reset8();
        gap_prev = 1'b0;
        gap_on   = 1'b1;
        e = '{7, 7, 7, 7, -7, -5, -3, -1};
        for (int r = 0; r < 16; r++) begin
            push(0, e, (r == 7) || (r == 15));
            for (int i = 0; i < 8; i++) send(0, 8'(i), 0);
        end
        idle();
        repeat (3) @(posedge clk);
        #1;
        gap_on = 1'b0;

        // ---------------- backpressure ----------------
        reset8();
        out_ready = 1'b0;
        e = '{7, 7, 7, 7, -7, -5, -3, -1};
        push(0, e, 0);
        for (int i = 0; i < 8; i++) send(0, 8'(i), 0);
        e = '{90, 90, 90, 90, -70, -50, -30, -10};
        push(0, e, 0);
        for (int i = 0; i < 8; i++) send(0, 8'(10 * (i + 1)), 0);
        check("stall in_ready low", 72'(in_ready), 72'd0);
        pix = 8'd5; shift = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall in_ready held", 72'(in_ready), 72'd0);
            check("stall out_valid held", 72'(out_valid), 72'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release in_ready", 72'(in_ready), 72'd1);
        check("release row2 valid", 72'(out_valid), 72'd1);
        e = '{10, 10, 10, 10, 0, 0, 0, 0};
        push(0, e, 0);
        for (int i = 0; i < 8; i++) send(0, 8'd5, 0);
        idle();
        repeat (3) @(posedge clk);
        #1;

        // ---------------- reset mid-row (N=8) ----------------
        e = '{7, 7, 7, 7, -7, -5, -3, -1};
        push(0, e, 0);
        for (int i = 0; i < 8; i++) send(0, 8'(i), 0);
        for (int i = 0; i < 5; i++) send(0, 8'(i + 1), 0);
        reset8();
        check("midrow reset out_valid", 72'(out_valid), 72'd0);
        check("midrow reset in_ready", 72'(in_ready), 72'd1);
        e = '{9, 9, 9, 9, -7, -5, -3, -1};
        push(0, e, 0);
        for (int i = 0; i < 8; i++) send(0, 8'(i + 1), 0);
        idle();

        // ---------------- N=4 instance ----------------
        e = '{3, 3, -3, -1, 0, 0, 0, 0};
        push(1, e, 0);
        for (int i = 0; i < 4; i++) send(1, 8'(i), 0);
        check("n4 latency", 72'(out_valid4), 72'd1);
        send(1, 8'd9, 0);
        idle();
        rst4 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst4 = 1'b0;
        check("n4 reset out_valid", 72'(out_valid4), 72'd0);
        check("n4 reset out_data", 72'(out_data4), 72'd0);
        e = '{5, 5, -3, -1, 0, 0, 0, 0};
        push(1, e, 0);
        for (int i = 0; i < 4; i++) send(1, 8'(i + 1), 0);
        e = '{-256, -256, 0, 0, 0, 0, 0, 0};
        push(1, e, 1);
        for (int i = 0; i < 4; i++) send(1, 8'd0, 1);
        idle();

        // ---------------- drain ----------------
        for (int i = 0; i < 200 && (q8.size() + q4.size()) != 0; i++) @(posedge clk);
        #1;
        check("scoreboard drained", 72'(q8.size() + q4.size()), 72'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_butterfly_row_stage
